// File: rtl/fetch_mem_arbiter.sv
// Arbitrates one memory port between instruction fetch and load/store, routes tagged returns.
// Zero-cycle grant and return routing; a rejected command leaves the requester holding its request.
module fetch_mem_arbiter #(
    parameter int XLEN          = 32,
    parameter int TAG_W         = 4,
    parameter int MAX_DC_STREAK = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             if_req,
    input  logic [XLEN-1:0]  if_addr,
    input  logic             if_flush,
    output logic             if_grant,
    output logic             if_rsp_valid,
    output logic [63:0]      if_rsp_data,
    input  logic             dc_req,
    input  logic [1:0]       dc_cmd,
    input  logic [XLEN-1:0]  dc_addr,
    input  logic [63:0]      dc_wdata,
    output logic             dc_grant,
    output logic [TAG_W-1:0] dc_grant_tag,
    output logic             dc_rsp_valid,
    output logic [TAG_W-1:0] dc_rsp_tag,
    output logic [63:0]      dc_rsp_data,
    output logic [1:0]       proc2mem_command,
    output logic [XLEN-1:0]  proc2mem_addr,
    output logic [63:0]      proc2mem_data,
    input  logic [TAG_W-1:0] mem2proc_response,
    input  logic [TAG_W-1:0] mem2proc_tag,
    input  logic [63:0]      mem2proc_data,
    output logic             proto_err
);
    localparam int ENTRIES = 1 << TAG_W;
    localparam int SW      = $clog2(MAX_DC_STREAK + 1);
    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;

    typedef enum logic [1:0] {SEL_NONE, SEL_IF, SEL_DC} sel_e;

    logic [ENTRIES-1:0] ent_vld, ent_dc, ent_disc;
    logic [ENTRIES-1:0] ent_vld_n, ent_dc_n, ent_disc_n;
    logic [SW-1:0]      streak;
    sel_e               sel;
    logic               if_elig, accept, alloc, ret_hit, ret_unknown;

    assign if_elig = if_req & ~if_flush;
    assign accept  = (mem2proc_response != '0);

    // DC wins unless fetch has already waited through a full streak.
    always_comb begin
        sel = SEL_NONE;
        if (dc_req && !(if_elig && streak == SW'(MAX_DC_STREAK)))
            sel = SEL_DC;
        else if (if_elig)
            sel = SEL_IF;
    end

    always_comb begin
        proc2mem_command = CMD_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        case (sel)
            SEL_IF: begin
                proc2mem_command = CMD_LOAD;
                proc2mem_addr    = if_addr;
            end
            SEL_DC: begin
                proc2mem_command = dc_cmd;
                proc2mem_addr    = dc_addr;
                if (dc_cmd == CMD_STORE)
                    proc2mem_data = dc_wdata;
            end
            default: ;
        endcase
    end

    assign if_grant     = (sel == SEL_IF) && accept;
    assign dc_grant     = (sel == SEL_DC) && accept;
    assign dc_grant_tag = (dc_grant && dc_cmd == CMD_LOAD) ? mem2proc_response : '0;
    assign alloc        = (if_grant || dc_grant) && proc2mem_command == CMD_LOAD;

    assign ret_hit      = (mem2proc_tag != '0) &&  ent_vld[mem2proc_tag];
    assign ret_unknown  = (mem2proc_tag != '0) && !ent_vld[mem2proc_tag];
    assign dc_rsp_valid = ret_hit && ent_dc[mem2proc_tag];
    assign dc_rsp_tag   = dc_rsp_valid ? mem2proc_tag : '0;
    assign dc_rsp_data  = dc_rsp_valid ? mem2proc_data : '0;
    assign if_rsp_valid = ret_hit && !ent_dc[mem2proc_tag] && !ent_disc[mem2proc_tag] && !if_flush;
    assign if_rsp_data  = if_rsp_valid ? mem2proc_data : '0;

    // Return clear is applied before allocation so a recycled tag ends up owned by the new load.
    always_comb begin
        ent_vld_n  = ent_vld;
        ent_dc_n   = ent_dc;
        ent_disc_n = ent_disc;
        if (if_flush)
            ent_disc_n = ent_disc | (ent_vld & ~ent_dc);
        if (ret_hit) begin
            ent_vld_n[mem2proc_tag]  = 1'b0;
            ent_dc_n[mem2proc_tag]   = 1'b0;
            ent_disc_n[mem2proc_tag] = 1'b0;
        end
        if (alloc) begin
            ent_vld_n[mem2proc_response]  = 1'b1;
            ent_dc_n[mem2proc_response]   = (sel == SEL_DC);
            ent_disc_n[mem2proc_response] = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ent_vld   <= '0;
            ent_dc    <= '0;
            ent_disc  <= '0;
            streak    <= '0;
            proto_err <= 1'b0;
        end else begin
            ent_vld   <= ent_vld_n;
            ent_dc    <= ent_dc_n;
            ent_disc  <= ent_disc_n;
            proto_err <= proto_err | ret_unknown;
            if (!if_req || if_grant)
                streak <= '0;
            else if (dc_grant && streak != SW'(MAX_DC_STREAK))
                streak <= streak + 1'b1;
        end
    end
endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Bench for fetch_mem_arbiter: directed scenarios plus randomized traffic against a tag-table model.
module tb_fetch_mem_arbiter;
    localparam int MAXS = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req, if_flush, if_grant, if_rsp_valid;
    logic [31:0] if_addr;
    logic [63:0] if_rsp_data;
    logic        dc_req, dc_grant, dc_rsp_valid;
    logic [1:0]  dc_cmd;
    logic [31:0] dc_addr;
    logic [63:0] dc_wdata, dc_rsp_data;
    logic [3:0]  dc_grant_tag, dc_rsp_tag;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data, mem2proc_data;
    logic [3:0]  mem2proc_response, mem2proc_tag;
    logic        proto_err;

    fetch_mem_arbiter dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_grant(if_grant),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .dc_req(dc_req), .dc_cmd(dc_cmd), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_grant(dc_grant), .dc_grant_tag(dc_grant_tag), .dc_rsp_valid(dc_rsp_valid),
        .dc_rsp_tag(dc_rsp_tag), .dc_rsp_data(dc_rsp_data),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data), .mem2proc_response(mem2proc_response),
        .mem2proc_tag(mem2proc_tag), .mem2proc_data(mem2proc_data), .proto_err(proto_err)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Model of outstanding tags: who owns each one and whether a flush has orphaned it.
    bit m_vld[16], m_dc[16], m_disc[16];
    int m_streak;
    bit m_perr;
    bit e_ifg, e_dcg, e_load;
    int e_sel;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < 16; i++) begin
            m_vld[i] = 0; m_dc[i] = 0; m_disc[i] = 0;
        end
        m_streak = 0;
        m_perr = 0;
    endtask

    task automatic idle();
        if_req = 0; if_addr = 0; if_flush = 0;
        dc_req = 0; dc_cmd = 0; dc_addr = 0; dc_wdata = 0;
        mem2proc_response = 0; mem2proc_tag = 0; mem2proc_data = 0;
    endtask

    task automatic eval();
        int sel, t;
        bit acc, ife, ifv, dcv;
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [63:0] data;
        logic [3:0]  gt;
        #1;
        ife = if_req && !if_flush;
        if (dc_req && !(ife && m_streak == MAXS)) sel = 2;
        else if (ife) sel = 1;
        else sel = 0;
        acc  = (mem2proc_response != 0);
        cmd  = (sel == 2) ? dc_cmd : ((sel == 1) ? 2'd1 : 2'd0);
        addr = (sel == 2) ? dc_addr : ((sel == 1) ? if_addr : 32'd0);
        data = (sel == 2 && dc_cmd == 2'd2) ? dc_wdata : 64'd0;
        e_sel  = sel;
        e_ifg  = (sel == 1) && acc;
        e_dcg  = (sel == 2) && acc;
        e_load = acc && cmd == 2'd1;
        gt = (e_dcg && dc_cmd == 2'd1) ? mem2proc_response : 4'd0;
        t = int'(mem2proc_tag);
        dcv = t != 0 && m_vld[t] && m_dc[t];
        ifv = t != 0 && m_vld[t] && !m_dc[t] && !m_disc[t] && !if_flush;
        chk("cmd", proc2mem_command, cmd);
        chk("addr", proc2mem_addr, addr);
        chk("wdata", proc2mem_data, data);
        chk("if_grant", if_grant, e_ifg);
        chk("dc_grant", dc_grant, e_dcg);
        chk("dc_grant_tag", dc_grant_tag, gt);
        chk("if_rsp_valid", if_rsp_valid, ifv);
        chk("if_rsp_data", if_rsp_data, ifv ? mem2proc_data : 64'd0);
        chk("dc_rsp_valid", dc_rsp_valid, dcv);
        chk("dc_rsp_data", dc_rsp_data, dcv ? mem2proc_data : 64'd0);
        if (dcv) chk("dc_rsp_tag", dc_rsp_tag, mem2proc_tag);
        chk("proto_err", proto_err, m_perr);
    endtask

    task automatic adv();
        int t, r;
        if (!reset) m_clear();
        else begin
            t = int'(mem2proc_tag);
            r = int'(mem2proc_response);
            if (if_flush)
                for (int i = 0; i < 16; i++)
                    if (m_vld[i] && !m_dc[i]) m_disc[i] = 1;
            if (t != 0) begin
                if (m_vld[t]) begin m_vld[t] = 0; m_dc[t] = 0; m_disc[t] = 0; end
                else m_perr = 1;
            end
            if (e_load) begin m_vld[r] = 1; m_dc[r] = (e_sel == 2); m_disc[r] = 0; end
            if (!if_req || e_ifg) m_streak = 0;
            else if (e_dcg && m_streak < MAXS) m_streak++;
        end
        @(negedge clock);
    endtask

    initial begin
        bit if_pend, dc_pend, pat[6];
        int r;
        pat = '{1, 1, 1, 1, 0, 1};
        idle();
        reset = 0;
        m_clear();
        @(negedge clock);
        eval();
        chk("rst_cmd", proc2mem_command, 2'd0);
        chk("rst_perr", proto_err, 1'b0);
        adv();
        reset = 1;

        // Single fetch, returned three cycles later.
        if_req = 1; if_addr = 32'h100; mem2proc_response = 5;
        eval();
        chk("if_issue_grant", if_grant, 1'b1);
        chk("if_issue_addr", proc2mem_addr, 32'h100);
        adv();
        idle(); eval(); adv();
        eval(); adv();
        mem2proc_tag = 5; mem2proc_data = 64'hAABB;
        eval();
        chk("if_ret_valid", if_rsp_valid, 1'b1);
        chk("if_ret_data", if_rsp_data, 64'hAABB);
        adv();

        // Both requesting: four DC grants then one forced IF grant.
        idle();
        for (int i = 0; i < 6; i++) begin
            if_req = 1; if_addr = 32'h1000 + 32'(i * 8);
            dc_req = 1; dc_cmd = 1; dc_addr = 32'h2000 + 32'(i * 4);
            mem2proc_response = 4'(i + 1);
            eval();
            chk("streak_dc", dc_grant, pat[i]);
            chk("streak_if", if_grant, !pat[i]);
            adv();
        end

        // Flush orphans an in-flight fetch and blocks fetch issue.
        idle();
        if_req = 1; if_addr = 32'h200; mem2proc_response = 2;
        eval(); chk("fl_grant", if_grant, 1'b1); adv();
        if_flush = 1; mem2proc_response = 9;
        eval(); chk("fl_blocked", if_grant, 1'b0); chk("fl_cmd", proc2mem_command, 2'd0); adv();
        idle(); mem2proc_tag = 2; mem2proc_data = 64'h55;
        eval(); chk("fl_drop", if_rsp_valid, 1'b0); adv();
        idle(); eval(); chk("fl_perr", proto_err, 1'b0); adv();

        // Rejected twice, accepted on the third try.
        dc_req = 1; dc_cmd = 1; dc_addr = 32'h300;
        for (int i = 0; i < 2; i++) begin
            eval(); chk("rej_grant", dc_grant, 1'b0); adv();
        end
        mem2proc_response = 4;
        eval(); chk("acc_grant", dc_grant, 1'b1); chk("acc_tag", dc_grant_tag, 4'd4); adv();

        // Store allocates nothing, so its tag coming back is a protocol error.
        idle();
        dc_req = 1; dc_cmd = 2; dc_addr = 32'h400; dc_wdata = 64'h1234; mem2proc_response = 7;
        eval();
        chk("st_grant", dc_grant, 1'b1);
        chk("st_tag", dc_grant_tag, 4'd0);
        chk("st_data", proc2mem_data, 64'h1234);
        adv();
        idle(); mem2proc_tag = 7;
        eval(); chk("st_ret", dc_rsp_valid, 1'b0); adv();
        idle(); eval(); chk("st_perr", proto_err, 1'b1); adv();

        reset = 0; m_clear(); eval(); chk("rst2_perr", proto_err, 1'b0); adv();
        reset = 1;

        if_pend = 0; dc_pend = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!if_pend && $urandom_range(2) == 0) begin
                if_pend = 1; if_addr = $urandom & 32'hFFFF_FFF8;
            end
            if (!dc_pend && $urandom_range(2) == 0) begin
                dc_pend = 1; dc_cmd = ($urandom_range(1) == 0) ? 2'd1 : 2'd2;
                dc_addr = $urandom; dc_wdata = {$urandom, $urandom};
            end
            if_req = if_pend; dc_req = dc_pend;
            if_flush = ($urandom_range(15) == 0);
            if ($urandom_range(3) == 0) mem2proc_response = 0;
            else begin
                r = $urandom_range(15, 1);
                for (int k = 0; k < 4 && m_vld[r]; k++) r = $urandom_range(15, 1);
                mem2proc_response = 4'(r);
            end
            r = 0;
            if ($urandom_range(1) == 0) begin
                r = $urandom_range(15, 1);
                if (!m_vld[r] && $urandom_range(199) != 0) r = 0;
            end
            mem2proc_tag = 4'(r);
            mem2proc_data = {$urandom, $urandom};
            eval();
            if (e_ifg) if_pend = 0;
            if (e_dcg) dc_pend = 0;
            adv();
        end

        // Reset mid-traffic, then an unknown tag returns.
        idle(); reset = 0; m_clear();
        eval();
        chk("mid_rst_cmd", proc2mem_command, 2'd0);
        chk("mid_rst_perr", proto_err, 1'b0);
        adv();
        reset = 1; mem2proc_tag = 3; mem2proc_data = 64'h77;
        eval();
        chk("mid_ret_if", if_rsp_valid, 1'b0);
        chk("mid_ret_dc", dc_rsp_valid, 1'b0);
        adv();
        idle(); eval(); chk("mid_perr", proto_err, 1'b1); adv();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fetch_mem_arbiter.md
Name: fetch_mem_arbiter

Overview:
- Shares the single 64-bit memory port between instruction fetch (IF) and the data path (load/store, DC).
- Issues one command per cycle. Records the owner of each outstanding load tag and steers each tagged return to the requester that issued it.
- Data requests win by default; a streak counter guarantees fetch forward progress.
- Supports a fetch flush that discards in-flight instruction returns.

Parameters:
- XLEN, 32, address width.
- TAG_W, 4, memory tag width; tag 0 means "no tag".
- MAX_DC_STREAK, 4, maximum consecutive DC grants while IF waits.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_grant
- if_addr  in  XLEN  fetch address, 8-byte aligned
- if_flush  in  1  squash all in-flight fetch returns
- if_grant  out  1  fetch command accepted this cycle
- if_rsp_valid  out  1  fetch data returned
- if_rsp_data  out  64  fetch return data
- dc_req  in  1  data request; held until dc_grant
- dc_cmd  in  2  1=LOAD, 2=STORE
- dc_addr  in  XLEN  data address
- dc_wdata  in  64  store data
- dc_grant  out  1  data command accepted this cycle
- dc_grant_tag  out  TAG_W  tag assigned to a granted load
- dc_rsp_valid  out  1  load data returned
- dc_rsp_tag  out  TAG_W  tag of the returned load
- dc_rsp_data  out  64  load return data
- proc2mem_command  out  2  0=NONE, 1=LOAD, 2=STORE
- proc2mem_addr  out  XLEN  memory address
- proc2mem_data  out  64  store data
- mem2proc_response  in  TAG_W  same-cycle accept tag; 0 = reject
- mem2proc_tag  in  TAG_W  tag of returning data; 0 = none
- mem2proc_data  in  64  returning data
- proto_err  out  1  sticky: return with an unknown tag

Behaviour:
- Reset (reset=0, asynchronous):
  - Owner table cleared: all entries valid=0, owner=0, discard=0.
  - Streak counter = 0.
  - proto_err = 0.
  - All combinational outputs derive from cleared state and inputs, so with no requests: proc2mem_command=NONE, grants=0, rsp_valid=0.
- Selection (combinational):
  - IF is eligible when if_req=1 and if_flush=0.
  - DC is selected if dc_req=1, unless IF is eligible and streak==MAX_DC_STREAK. Otherwise IF is selected if eligible. Otherwise NONE.
  - proc2mem_* come from the selected source. IF always issues LOAD; proc2mem_data=0 for loads and NONE.
  - When NONE: proc2mem_addr=0.
- Grant:
  - Selected source is granted iff mem2proc_response!=0 in the same cycle.
  - dc_grant_tag=mem2proc_response on a granted DC load, else 0.
  - On reject, no grant; the requester holds its request and state is unchanged.
- Owner table (2^TAG_W entries, registered):
  - A granted load sets entry[response]: valid=1, owner=IF/DC, discard=0.
  - A granted store allocates nothing.
- Returns (mem2proc_tag!=0):
  - Valid entry, owner=DC: dc_rsp_valid=1, dc_rsp_tag=tag, dc_rsp_data=mem2proc_data.
  - Valid entry, owner=IF, discard=0, if_flush=0: if_rsp_valid=1, if_rsp_data=mem2proc_data.
  - IF return with discard=1 or if_flush=1: dropped silently.
  - Entry is cleared in all of the above cases.
  - Invalid entry: dropped, proto_err<=1 (held until reset).
  - rsp_data=0 whenever the matching rsp_valid=0.
- Same cycle, return tag == newly granted tag: clear is applied first, then the new allocation; the entry ends valid with the new owner.
- if_flush=1: every valid IF entry gets discard<=1. IF issue is blocked that cycle; DC is unaffected.
- Streak counter:
  - +1 (saturating at MAX_DC_STREAK) on a DC grant while if_req=1.
  - Reset to 0 on an IF grant, or when if_req=0.
  - Unchanged on reject.
- Latency: grant is 0-cycle, combinational from request and response. Return routing is 0-cycle, combinational from mem2proc_tag.

Test Plan:
- Reset with reset=0 mid-traffic (entries valid) -> all outputs 0, proc2mem_command=NONE; later return with tag 3 -> proto_err=1, no rsp_valid.
- if_req only, addr 0x100, response=5; 3 cycles later mem2proc_tag=5, data 0xAABB -> if_grant=1 in the issue cycle; if_rsp_valid=1 with data 0xAABB; entry 5 cleared.
- if_req and dc_req (LOAD) held continuously, all accepted -> grant pattern DC,DC,DC,DC,IF,DC,... ; counter returns to 0 after the IF grant.
- IF load granted tag 2, if_flush pulse, then tag 2 returns -> if_rsp_valid=0, no proto_err; IF request during the flush cycle not granted.
- DC STORE, response=7 -> dc_grant=1, dc_grant_tag=0, no entry allocated; later mem2proc_tag=7 -> proto_err=1.
- mem2proc_response=0 for 2 cycles with dc_req held -> no grant, streak unchanged; grant on 3rd cycle when response=4, dc_grant_tag=4.
